if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request, one instruction held for decode,
// and a PC that is redirected only after the current instruction executes.
module if_stage #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] pcn_i,
    input  logic                  pcn_valid_i,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  misalign_o,
    output logic [63:0]           fetch_cnt_o,
    output logic [2:0]            state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // valid depends only on state, never on the matching ready, and payloads (imem_addr_o,
    // inst_o, pc_o) stay constant while valid is high and the transfer has not happened.
    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        ISSUE = 3'd2,
        EXEC  = 3'd3,
        TRAP  = 3'd4
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [DATA_WIDTH-1:0]   pc_q;
    logic [INST_WIDTH-1:0]   inst_q;
    logic                    misalign_q;
    logic [63:0]             cnt_q;
    logic                    pcn_aligned;

    assign pcn_aligned = (pcn_i[1:0] == 2'b00);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == WAIT && imem_rsp_valid_i) begin
                inst_q <= imem_rsp_data_i;
            end
            if (state_q == ISSUE && inst_ready_i) begin
                cnt_q <= cnt_q + 64'd1;
            end
            // A misaligned target leaves the PC pointing at the instruction that produced it.
            if (state_q == EXEC && pcn_valid_i) begin
                if (pcn_aligned) begin
                    pc_q <= pcn_i;
                end else begin
                    misalign_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        imem_req_valid_o = 1'b0;
        inst_valid_o     = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req_valid_o = 1'b1;
                if (imem_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                inst_valid_o = 1'b1;
                if (inst_ready_i) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (pcn_valid_i) begin
                    state_d = pcn_aligned ? FETCH : TRAP;
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;
    assign misalign_o  = misalign_q;
    assign fetch_cnt_o = cnt_q;
    assign state_o     = state_q;

endmodule
